// File: rtl/nios_dbg_pkg.sv
// Shared types and sizing helpers for the Nios II debug command capture path.
package nios_dbg_pkg;

    localparam int TS_W     = 16;
    localparam int IR_W_DEF = 2;
    localparam int DR_W_DEF = 38;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [DR_W_DEF-1:0] data;
        logic [TS_W-1:0]     ts;
    } dbg_cmd_t;

    // Occupancy / pointer width: one extra bit distinguishes full from empty.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/nios_dbg_bit_sync.sv
// Multi-flop synchroniser for one TCK-domain level into the system clock domain.
module nios_dbg_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/nios_dbg_cmd_sync.sv
// Captures {ir, sr, ts} on each synchronised update-DR into a FWFT command FIFO.
// Optional per-entry timestamps are enabled with DBG_CMD_TIMESTAMP_EN.
module nios_dbg_cmd_sync
    import nios_dbg_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_udr,
    input  logic                     vs_uir,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [DR_W-1:0]          sr,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [DR_W-1:0]          cmd_data,
    output logic [TS_W-1:0]          cmd_ts,
    output logic                     uir_pulse,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int LVL_W = lvl_w(DEPTH);
    localparam int AW    = LVL_W - 1;

    logic udr_sync;
    logic uir_sync;
    logic udr_hist_q, udr_hist_d;
    logic uir_hist_q, uir_hist_d;
    logic udr_evt;

    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;

    logic [IR_W-1:0]  ir_mem_q   [DEPTH];
    logic [IR_W-1:0]  ir_mem_d   [DEPTH];
    logic [DR_W-1:0]  data_mem_q [DEPTH];
    logic [DR_W-1:0]  data_mem_d [DEPTH];

    nios_dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (vs_udr),
        .q       (udr_sync)
    );

    nios_dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (vs_uir),
        .q       (uir_sync)
    );

    // Rising-edge detection: one event per synchronised low-to-high transition.
    always_comb begin
        udr_hist_d = udr_sync;
        uir_hist_d = uir_sync;
        udr_evt    = udr_sync & ~udr_hist_q;
        uir_pulse  = uir_sync & ~uir_hist_q;
    end

    always_comb begin
        wr_idx = wr_ptr_q[AW-1:0];
        rd_idx = rd_ptr_q[AW-1:0];
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        empty  = (wr_ptr_q == rd_ptr_q);
        pop    = !empty && cmd_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push   = udr_evt && (!full || pop);

        wr_ptr_d = wr_ptr_q + {{(LVL_W-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(LVL_W-1){1'b0}}, pop};

        if (udr_evt && full && !pop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        ir_mem_d   = ir_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            ir_mem_d[wr_idx]   = ir_in;
            data_mem_d[wr_idx] = sr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_hist_q <= 1'b0;
            uir_hist_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            udr_hist_q <= udr_hist_d;
            uir_hist_q <= uir_hist_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: outputs are gated to zero while empty.
    always_ff @(posedge clk) begin
        ir_mem_q   <= ir_mem_d;
        data_mem_q <= data_mem_d;
    end

`ifdef DBG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic [TS_W-1:0] ts_mem_q [DEPTH];
    logic [TS_W-1:0] ts_mem_d [DEPTH];

    always_comb begin
        ts_d     = ts_q + 1'b1;
        ts_mem_d = ts_mem_q;
        if (push) begin
            ts_mem_d[wr_idx] = ts_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    always_ff @(posedge clk) begin
        ts_mem_q <= ts_mem_d;
    end

    assign cmd_ts = empty ? '0 : ts_mem_q[rd_idx];
`else
    assign cmd_ts = '0;
`endif

    assign cmd_valid = !empty;
    assign cmd_ir    = empty ? '0 : ir_mem_q[rd_idx];
    assign cmd_data  = empty ? '0 : data_mem_q[rd_idx];
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = ovf_q;

endmodule
